alu_seq: RTL and testbench

//  Multi-byte operation sequencer; the initiator side of the 8-bit ALU interface.

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq.sv | 118 +++++++++++
 tb/tb_alu_seq.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the multi-byte ALU sequencer: op encodings, FSM states,
// and the pad bits appended to the op when forming the ALU command.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_XOR = 3'b100,
        OP_OR  = 3'b101,
        OP_AND = 3'b110,
        OP_SRL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] ALU_CMD_PAD = 2'b00;

    // ADD is the only legal op with op[2] clear.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_ADD) || op[2];
    endfunction

endpackage

// File: rtl/alu_seq.sv
// Multi-byte sequencer: accepts one wide request, walks the 8-bit ALU one byte
// per cycle with carry/shift chaining, then presents the assembled response.
//
//  state | meaning
//  IDLE  | ready for a request; ALU and response outputs held at 0
//  EXEC  | one byte lane per cycle through the ALU, idx walks up (SRL: down)
//  DONE  | response valid and held until rsp_ready
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [8*NBYTES-1:0]   req_a,
    input  logic [8*NBYTES-1:0]   req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_data,
    output logic                  rsp_carry,
    output logic                  rsp_zero,
    output logic                  rsp_pari,
    output logic                  rsp_err,
    output logic [4:0]            alu_cmd,
    output logic [7:0]            alu_inA,
    output logic [7:0]            alu_inB,
    output logic                  alu_sc_i,
    input  logic [7:0]            alu_rslt,
    input  logic                  alu_sc_o
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES) + 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

    state_e          state_q, state_d;
    logic [2:0]      op_q;
    logic [W-1:0]    a_q, b_q, res_q;
    logic            carry_q, err_q;
    logic [IW-1:0]   idx_q;
    logic [IW+2:0]   lane;
    logic            is_srl, last_byte, in_exec, in_done;

    assign is_srl    = (op_q == OP_SRL);
    assign lane      = {idx_q, 3'b000};
    assign last_byte = is_srl ? (idx_q == '0) : (idx_q == IDX_LAST);
    assign in_exec   = (state_q == EXEC);
    assign in_done   = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = is_legal_op(req_op) ? EXEC : DONE;
            EXEC:    if (last_byte) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        a_q     <= req_a;
                        b_q     <= req_b;
                        res_q   <= '0;
                        carry_q <= 1'b0;
                        err_q   <= !is_legal_op(req_op);
                        idx_q   <= (req_op == OP_SRL) ? IDX_LAST : '0;
                    end
                end
                EXEC: begin
                    res_q[lane +: 8] <= alu_rslt;
                    // Logic ops never chain, so their carry stays at the cleared 0.
                    if (op_q == OP_ADD || is_srl) carry_q <= alu_sc_o;
                    idx_q <= is_srl ? idx_q - 1'b1 : idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);

    assign alu_cmd  = in_exec ? {op_q, ALU_CMD_PAD} : '0;
    assign alu_inA  = in_exec ? a_q[lane +: 8] : '0;
    assign alu_inB  = (in_exec && !is_srl) ? b_q[lane +: 8] : '0;
    assign alu_sc_i = in_exec & carry_q;

    assign rsp_valid = in_done;
    assign rsp_data  = in_done ? res_q : '0;
    assign rsp_carry = in_done & carry_q;
    assign rsp_err   = in_done & err_q;
    assign rsp_zero  = in_done & (res_q == '0);
    assign rsp_pari  = in_done & (^res_q);

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: bench-side 8-bit ALU, whole-word reference model checked
// every cycle, directed corner cases with literal expectations, random traffic.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int NB = 2;
    localparam int W  = 8 * NB;
    localparam logic [63:0] WMASK = (64'd1 << W) - 64'd1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_a, req_b;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_carry, rsp_zero, rsp_pari, rsp_err;
    logic [4:0]   alu_cmd;
    logic [7:0]   alu_inA, alu_inB, alu_rslt;
    logic         alu_sc_i, alu_sc_o;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  rand_mode = 1'b0;

    always #5 clk = ~clk;

    alu_seq #(.NBYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_pari(rsp_pari),
        .rsp_err(rsp_err),
        .alu_cmd(alu_cmd), .alu_inA(alu_inA), .alu_inB(alu_inB),
        .alu_sc_i(alu_sc_i), .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o)
    );

    // 8-bit ALU with the full op table, combinational.
    always_comb begin
        logic [8:0] s;
        s        = {1'b0, alu_inA} + {1'b0, alu_inB} + {8'd0, alu_sc_i};
        alu_rslt = 8'h00;
        alu_sc_o = 1'b0;
        case (alu_cmd[4:2])
            3'b000: {alu_sc_o, alu_rslt} = s;
            3'b100: alu_rslt = alu_inA ^ alu_inB;
            3'b101: alu_rslt = alu_inA | alu_inB;
            3'b110: alu_rslt = alu_inA & alu_inB;
            3'b111: begin
                alu_rslt = {alu_sc_i, alu_inA[7:1]};
                alu_sc_o = alu_inA[0];
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: whole-word results, per-cycle phase of the current transaction.
    bit          m_exec = 1'b0, m_done = 1'b0;
    int          m_k = 0;
    logic [2:0]  m_op = 3'b000;
    logic [63:0] m_a = '0, m_b = '0, e_data = '0;
    bit          e_carry = 1'b0, e_err = 1'b0;

    always @(negedge clk) begin : compare
        logic [63:0] ea, eb, lm, tmp, s;
        logic [4:0]  ecmd;
        bit          esc;
        int          j;
        if (!rst_n) begin
            m_exec = 1'b0;
            m_done = 1'b0;
        end
        chk("req_ready", req_ready, !(m_exec || m_done));
        chk("rsp_valid", rsp_valid, m_done);
        chk("rsp_data",  rsp_data,  m_done ? e_data : 64'd0);
        chk("rsp_carry", rsp_carry, m_done && e_carry);
        chk("rsp_err",   rsp_err,   m_done && e_err);
        chk("rsp_zero",  rsp_zero,  m_done && (e_data == 64'd0));
        chk("rsp_pari",  rsp_pari,  m_done && (^e_data));

        ecmd = '0; ea = '0; eb = '0; esc = 1'b0;
        if (m_exec) begin
            j    = (m_op == 3'b111) ? (NB - 1 - m_k) : m_k;
            ecmd = {m_op, 2'b00};
            ea   = (m_a >> (8 * j)) & 64'hFF;
            eb   = (m_op == 3'b111) ? 64'd0 : ((m_b >> (8 * j)) & 64'hFF);
            if (m_op == 3'b000) begin
                lm  = (64'd1 << (8 * j)) - 64'd1;
                tmp = ((m_a & lm) + (m_b & lm)) >> (8 * j);
                esc = tmp[0];
            end else if (m_op == 3'b111 && j != NB - 1) begin
                tmp = m_a >> (8 * (j + 1));
                esc = tmp[0];
            end
        end
        chk("alu_cmd",  alu_cmd,  ecmd);
        chk("alu_inA",  alu_inA,  ea);
        chk("alu_inB",  alu_inB,  eb);
        chk("alu_sc_i", alu_sc_i, esc);

        if (rst_n) begin
            if (m_exec) begin
                m_k++;
                if (m_k == NB) begin
                    m_exec = 1'b0;
                    m_done = 1'b1;
                end
            end else if (m_done) begin
                if (rsp_ready) m_done = 1'b0;
            end else if (req_valid) begin
                m_op = req_op;
                m_a  = 64'(req_a);
                m_b  = 64'(req_b);
                e_carry = 1'b0;
                e_err   = 1'b0;
                case (req_op)
                    3'b000: begin
                        s = m_a + m_b;
                        e_data  = s & WMASK;
                        e_carry = s[W];
                    end
                    3'b100: e_data = m_a ^ m_b;
                    3'b101: e_data = m_a | m_b;
                    3'b110: e_data = m_a & m_b;
                    3'b111: begin
                        e_data  = m_a >> 1;
                        e_carry = m_a[0];
                    end
                    default: begin
                        e_data = 64'd0;
                        e_err  = 1'b1;
                    end
                endcase
                m_k = 0;
                if (e_err) m_done = 1'b1;
                else m_exec = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; returns at the accepting posedge + 1.
    task automatic do_req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic rdy;
        int   cnt;
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            cnt++;
        end while (!rdy && cnt < 50);
        if (!rdy) chk("accept_timeout", 64'(cnt), 64'd0);
        #1;
        req_valid = 1'b0;
    endtask

    // Returns at the first negedge showing rsp_valid; n counts negedges waited.
    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [W-1:0] held;
        logic [2:0]   op;
        logic [W-1:0] a, b;
        int           r;

        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(OP_ADD, 16'h00FF, 16'h0001);
        wait_rsp(n);
        chk("t1_latency", n, NB + 1);
        chk("t1_data", rsp_data, 16'h0100);
        chk("t1_carry", rsp_carry, 0);
        chk("t1_zero", rsp_zero, 0);
        chk("t1_pari", rsp_pari, 1);
        @(posedge clk); #1;

        do_req(OP_ADD, 16'hFFFF, 16'h0001);
        wait_rsp(n);
        chk("t2_data", rsp_data, 16'h0000);
        chk("t2_carry", rsp_carry, 1);
        chk("t2_zero", rsp_zero, 1);
        chk("t2_pari", rsp_pari, 0);
        @(posedge clk); #1;

        do_req(OP_SRL, 16'h8001, 16'h1234);
        @(negedge clk);
        chk("t3_ms_inA", alu_inA, 8'h80);
        chk("t3_ms_sc_i", alu_sc_i, 0);
        @(negedge clk);
        chk("t3_ls_inA", alu_inA, 8'h01);
        chk("t3_ls_sc_i", alu_sc_i, 0);
        @(negedge clk);
        chk("t3_srl_valid", rsp_valid, 1);
        chk("t3_srl_data", rsp_data, 16'h4000);
        chk("t3_srl_carry", rsp_carry, 1);
        @(posedge clk); #1;

        do_req(OP_XOR, 16'hA5A5, 16'hA5A5);
        wait_rsp(n);
        chk("t3_xor_data", rsp_data, 16'h0000);
        chk("t3_xor_zero", rsp_zero, 1);
        chk("t3_xor_carry", rsp_carry, 0);
        @(posedge clk); #1;

        rsp_ready = 1'b0;
        do_req(OP_ADD, 16'h1234, 16'h1111);
        wait_rsp(n);
        held = rsp_data;
        chk("t4_data", held, 16'h2345);
        @(posedge clk); #1;
        req_op = OP_OR; req_a = 16'hF0F0; req_b = 16'h0F0F; req_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold_data", rsp_data, 16'h2345);
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t4_ready_after_hs", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("t4_accepted_cmd", alu_cmd, 5'b10100);
        wait_rsp(n);
        chk("t4_or_data", rsp_data, 16'hFFFF);
        chk("t4_or_pari", rsp_pari, 0);
        @(posedge clk); #1;

        do_req(3'b010, 16'h1234, 16'h5678);
        @(negedge clk);
        chk("t5_valid", rsp_valid, 1);
        chk("t5_err", rsp_err, 1);
        chk("t5_data", rsp_data, 0);
        chk("t5_cmd", alu_cmd, 0);
        @(posedge clk); #1;

        do_req(OP_XOR, 16'h00FF, 16'hFF00);
        chk("t6_pre_cmd", alu_cmd, 5'b10000);
        rst_n = 1'b0;
        #1;
        chk("t6_cmd", alu_cmd, 0);
        chk("t6_inA", alu_inA, 0);
        chk("t6_inB", alu_inB, 0);
        chk("t6_valid", rsp_valid, 0);
        chk("t6_data", rsp_data, 0);
        chk("t6_ready", req_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_no_spurious", rsp_valid, 0);
        @(posedge clk); #1;
        do_req(OP_ADD, 16'h1234, 16'h4321);
        wait_rsp(n);
        chk("t6_post_data", rsp_data, 16'h5555);
        chk("t6_post_latency", n, NB + 1);
        @(posedge clk); #1;

        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 7: op = OP_ADD;
                2:       op = OP_XOR;
                3:       op = OP_OR;
                4:       op = OP_AND;
                5, 6, 8: op = OP_SRL;
                default: op = 3'($urandom_range(1, 3));
            endcase
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 7) == 0) a = '1;
            if ($urandom_range(0, 7) == 0) b = W'(1);
            if ($urandom_range(0, 9) == 0) a = '0;
            do_req(op, a, b);
        end
        rand_mode = 1'b0;
        #2;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
